branch_resolve_buffer: RTL and testbench
========================================

// Module: branch_resolve_buffer
// PURPOSE
//  Sits between the branch functional units (Complete stage) and the branch stack.
//  Collects branch outcomes from N_BR_FU units and holds them in a table indexed by b-mask bit.
//  Emits at most one resolution per cycle as b_mm_resolve/b_mm_mispred/resolve_target.
//  Oldest mispredict goes first; entries killed by an emitted mispredict are dropped.
// PARAMETERS
//  B_MASK_W   `B_MASK_WIDTH (4)  number of branch-stack slots = table entries
//  N_BR_FU    2                  branch results accepted per cycle
//  ADDR_W     32                 target PC width
// PORTS
//  clock           in   1               single clock, posedge
//  reset           in   1               asynchronous, active-low (0 = reset)
//  br_valid        in   N_BR_FU         result valid per FU
//  br_b_mm         in   N_BR_FU*B_MASK_W  one-hot: the branch's own stack bit
//  br_b_mask       in   N_BR_FU*B_MASK_W  branches older than it still unresolved (dependency mask)
//  br_mispred      in   N_BR_FU         1 = outcome differs from prediction
//  br_target       in   N_BR_FU*ADDR_W  correct next PC
//  b_mm_resolve    out  B_MASK_W        one-hot resolved bit, 0 = none this cycle
//  b_mm_mispred    out  1               resolved branch mispredicted (only with b_mm_resolve!=0)
//  resolve_target  out  ADDR_W          correct PC for the resolved branch
//  pending_cnt     out  $clog2(B_MASK_W+1)  valid table entries
// BEHAVIOUR
//  - Reset (async, reset==0): all entries invalid; b_mm_resolve=0, b_mm_mispred=0, resolve_target=0, pending_cnt=0.
//  - Entry e: valid, mispred, dep[B_MASK_W], target. Write at posedge into slot = onehot index of br_b_mm.
//  - Select (combinational from table state): ready mispredicts = valid & mispred & (dep & valid_mispred_bits)==0.
//    If any exist, pick the lowest index. Else pick the lowest-index valid entry. Outputs are driven from the selected entry.
//  - Latency: input at edge k -> earliest output during cycle k+1.
//  - Posedge update, for emitted bit m:
//     * entry m invalidated.
//     * If correct: clear bit m from dep of all entries and of same-cycle incoming results.
//     * If mispred: invalidate every entry with dep[m]=1; drop incoming results with br_b_mask[m]=1; other incoming are written.
//  - Capacity is exactly B_MASK_W. Overflow is impossible; no back-pressure port.
//    Write to an already-valid slot, or two FUs with the same br_b_mm in one cycle = protocol error (assertion).
//  - Incoming with br_b_mm==m of the emitted bit in same cycle: write wins (slot freed then refilled).
//  - Reset mid-operation: table cleared immediately; outputs 0 within the same cycle.
// CONFIGURATION
//  BR_RESOLVE_BYPASS_EN defined: when pending_cnt==0 and br_valid!=0, the same select rule is applied to incoming results
//    and driven to outputs the same cycle (0 latency). The bypassed result is not written; the others are written, with squash/clear rules applied.
//  Undefined: no bypass; latency is always >=1 cycle.
// STRUCTURE
//  sys_defs.svh: BR_RESULT_PACKET {b_mm, b_mask, mispred, target}, BR_RESOLVE_ENTRY {valid, mispred, dep, target}.
//  Reuse B_MASK, B_MASK_MASK, ADDR.
//  Sub-module br_resolve_select: pure combinational picker (entries -> one-hot grant + mispred flag). Reused by the bypass path.
// TESTING
//  1 Reset with reset=0 mid-traffic: all outputs 0 and pending_cnt=0 in that cycle; stays 0 until new input.
//  2 FU0 writes correct br b_mm=0010, dep=0000: next cycle b_mm_resolve=0010, mispred=0; pending_cnt returns to 0.
//  3 Same cycle: b_mm=0001 mispred dep=0000 and b_mm=0100 mispred dep=0001.
//    -> emits 0001 mispred, target of 0001; slot 0100 squashed, never emitted.
//  4 Entries 0010 correct (dep 0000) and 1000 mispred (dep 0010) pending:
//    1000 is ready (0010 not mispred) -> 1000 emitted first, then 0010 (not dependent on 1000).
//  5 While 0001 mispred is emitted, FU1 delivers b_mm=0100 with b_mask=0001 -> dropped; pending_cnt unchanged by it.
//  6 BYPASS_EN, empty table, FU0 b_mm=0100 correct -> b_mm_resolve=0100 same cycle; pending_cnt stays 0.
//    Without the macro it appears one cycle later.

Source files
------------

// File: rtl/branch_resolve_buffer_pkg.sv
// Shared types and sizes for the branch resolve buffer: result packets, table entries, b-mask helpers.
// B_MASK_WIDTH may be defined externally to resize the branch stack (default 4 slots).
`ifndef B_MASK_WIDTH
`define B_MASK_WIDTH 4
`endif

package branch_resolve_buffer_pkg;

  localparam int B_MASK_W = `B_MASK_WIDTH;
  localparam int N_BR_FU  = 2;
  localparam int ADDR_W   = 32;
  localparam int CNT_W    = $clog2(B_MASK_W + 1);

  typedef logic [B_MASK_W-1:0] b_mask_t;
  typedef logic [ADDR_W-1:0]   addr_t;

  localparam b_mask_t B_MASK_MASK = '1;

  typedef struct packed {
    b_mask_t b_mm;
    b_mask_t b_mask;
    logic    mispred;
    addr_t   target;
  } br_result_packet_t;

  typedef struct packed {
    logic    valid;
    logic    mispred;
    b_mask_t dep;
    addr_t   target;
  } br_resolve_entry_t;

  function automatic logic [CNT_W-1:0] count_ones(input b_mask_t m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < B_MASK_W; i++) begin
      c = c + CNT_W'(m[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/branch_resolve_buffer_if.sv
// Branch-unit results into the resolve buffer and the single per-cycle resolution out of it.
// slave = the buffer itself; master = the FU / branch-stack side.
interface branch_resolve_buffer_if;
  import branch_resolve_buffer_pkg::*;

  logic              [N_BR_FU-1:0] br_valid;
  br_result_packet_t [N_BR_FU-1:0] br_res;
  b_mask_t                         b_mm_resolve;
  logic                            b_mm_mispred;
  addr_t                           resolve_target;
  logic              [CNT_W-1:0]   pending_cnt;

  modport master (
    output br_valid, br_res,
    input  b_mm_resolve, b_mm_mispred, resolve_target, pending_cnt
  );

  modport slave (
    input  br_valid, br_res,
    output b_mm_resolve, b_mm_mispred, resolve_target, pending_cnt
  );
endinterface

// File: rtl/br_resolve_select.sv
// Combinational picker: oldest ready mispredict first, otherwise lowest-index valid entry.
// Zero latency; one-hot grant, all-zero when nothing is valid.
module br_resolve_select
  import branch_resolve_buffer_pkg::*;
(
  input  b_mask_t                valid_i,
  input  b_mask_t                mispred_i,
  input  b_mask_t [B_MASK_W-1:0] dep_i,
  output b_mask_t                grant_o,
  output logic                   mispred_o
);
  b_mask_t vm;
  b_mask_t ready_mp;
  b_mask_t cand;

  always_comb begin
    vm       = valid_i & mispred_i;
    ready_mp = '0;
    // A mispredict is ready once no older branch it depends on is itself a pending mispredict.
    for (int e = 0; e < B_MASK_W; e++) begin
      ready_mp[e] = vm[e] && ((dep_i[e] & vm) == '0);
    end
    cand      = (ready_mp != '0) ? ready_mp : valid_i;
    grant_o   = cand & (~cand + b_mask_t'(1));
    mispred_o = |(grant_o & vm);
  end
endmodule

// File: rtl/branch_resolve_buffer.sv
// Collects branch outcomes per b-mask slot and emits one resolution per cycle (latency 1, or 0 with
// BR_RESOLVE_BYPASS_EN on an empty table); no backpressure, capacity equals the number of stack slots.
module branch_resolve_buffer
  import branch_resolve_buffer_pkg::*;
(
  input logic                    clock,
  input logic                    reset,
  branch_resolve_buffer_if.slave br_io
);
  br_resolve_entry_t [B_MASK_W-1:0] tab_q;
  br_resolve_entry_t [B_MASK_W-1:0] tab_d;
  br_resolve_entry_t [B_MASK_W-1:0] in_tab;
  br_resolve_entry_t [B_MASK_W-1:0] sel_tab;
  b_mask_t                          valid_bits;
  b_mask_t                          sel_valid;
  b_mask_t                          sel_mp;
  b_mask_t [B_MASK_W-1:0]           sel_dep;
  b_mask_t                          grant;
  b_mask_t                          clr_mask;
  logic                             grant_mp;
  logic                             byp;
  addr_t                            tgt;

  always_comb begin
    in_tab = '0;
    for (int f = 0; f < N_BR_FU; f++) begin
      for (int e = 0; e < B_MASK_W; e++) begin
        if (br_io.br_valid[f] && br_io.br_res[f].b_mm[e]) begin
          in_tab[e].valid   = 1'b1;
          in_tab[e].mispred = br_io.br_res[f].mispred;
          in_tab[e].dep     = br_io.br_res[f].b_mask;
          in_tab[e].target  = br_io.br_res[f].target;
        end
      end
    end
  end

  always_comb begin
    valid_bits = '0;
    for (int e = 0; e < B_MASK_W; e++) begin
      valid_bits[e] = tab_q[e].valid;
    end
  end

`ifdef BR_RESOLVE_BYPASS_EN
  // Reset gates the bypass so outputs stay zero while reset is held.
  assign byp = reset && (valid_bits == '0) && (|br_io.br_valid);
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    sel_tab   = byp ? in_tab : tab_q;
    sel_valid = '0;
    sel_mp    = '0;
    sel_dep   = '0;
    for (int e = 0; e < B_MASK_W; e++) begin
      sel_valid[e] = sel_tab[e].valid;
      sel_mp[e]    = sel_tab[e].mispred;
      sel_dep[e]   = sel_tab[e].dep;
    end
  end

  br_resolve_select u_select (
    .valid_i   (sel_valid),
    .mispred_i (sel_mp),
    .dep_i     (sel_dep),
    .grant_o   (grant),
    .mispred_o (grant_mp)
  );

  assign clr_mask = grant_mp ? B_MASK_MASK : (B_MASK_MASK ^ grant);

  always_comb begin
    tab_d = tab_q;
    for (int e = 0; e < B_MASK_W; e++) begin
      tab_d[e].dep = tab_q[e].dep & clr_mask;
      if (grant[e] || (grant_mp && ((tab_q[e].dep & grant) != '0))) begin
        tab_d[e].valid = 1'b0;
      end
    end
    // Incoming results land after the release, so a refill of the emitted slot wins.
    for (int e = 0; e < B_MASK_W; e++) begin
      if (in_tab[e].valid && !(byp && grant[e]) &&
          !(grant_mp && ((in_tab[e].dep & grant) != '0))) begin
        tab_d[e]     = in_tab[e];
        tab_d[e].dep = in_tab[e].dep & clr_mask;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tab_q <= '0;
    end else begin
      tab_q <= tab_d;
    end
  end

  always_comb begin
    tgt = '0;
    for (int e = 0; e < B_MASK_W; e++) begin
      if (grant[e]) tgt = sel_tab[e].target;
    end
  end

  assign br_io.b_mm_resolve   = grant;
  assign br_io.b_mm_mispred   = grant_mp;
  assign br_io.resolve_target = tgt;
  assign br_io.pending_cnt    = count_ones(valid_bits);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int f = 0; f < N_BR_FU; f++) begin
        if (br_io.br_valid[f]) assert ($onehot(br_io.br_res[f].b_mm));
      end
      assert (!(&br_io.br_valid && (br_io.br_res[0].b_mm == br_io.br_res[1].b_mm)));
      for (int e = 0; e < B_MASK_W; e++) begin
        assert (!(in_tab[e].valid && tab_q[e].valid && !grant[e]));
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_buffer.sv
// Bench for branch_resolve_buffer: directed vector table, hand-written corner sequences, random traffic vs a queue model.
module tb_branch_resolve_buffer;
  import branch_resolve_buffer_pkg::*;

  typedef struct { bit v; bit [3:0] mm; bit [3:0] mask; bit mp; bit [31:0] tgt; } fu_t;
  typedef struct { fu_t f0; fu_t f1; bit [3:0] res; bit mp; bit [31:0] tgt; int cnt; } vec_t;
  typedef struct { int slot; bit mp; bit [3:0] dep; bit [31:0] tgt; } rec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  rec_t pend[$];
  vec_t vt[$];

  always #5 clock = ~clock;

  branch_resolve_buffer_if br_if();
  branch_resolve_buffer dut (.clock(clock), .reset(reset), .br_io(br_if));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input bit [3:0] res, input bit mp,
                           input bit [31:0] tgt, input int cnt);
    check({tag, ".resolve"}, 32'(br_if.b_mm_resolve), 32'(res));
    check({tag, ".mispred"}, 32'(br_if.b_mm_mispred), 32'(mp));
    check({tag, ".target"},  br_if.resolve_target, tgt);
    check({tag, ".pending"}, 32'(br_if.pending_cnt), 32'(cnt));
  endtask

  function automatic fu_t mk(bit v, bit [3:0] mm, bit [3:0] mask, bit mp, bit [31:0] tgt);
    fu_t f;
    f.v = v; f.mm = mm; f.mask = mask; f.mp = mp; f.tgt = tgt;
    return f;
  endfunction

  function automatic vec_t vv(fu_t a, fu_t b, bit [3:0] res, bit mp, bit [31:0] tgt, int cnt);
    vec_t x;
    x.f0 = a; x.f1 = b; x.res = res; x.mp = mp; x.tgt = tgt; x.cnt = cnt;
    return x;
  endfunction

  function automatic rec_t mkrec(fu_t f);
    rec_t r;
    r.slot = -1;
    for (int i = 0; i < 4; i++) if (f.mm[i]) r.slot = i;
    r.mp = f.mp; r.dep = f.mask; r.tgt = f.tgt;
    return r;
  endfunction

  task automatic drive(input fu_t a, input fu_t b);
    br_if.br_valid  = {b.v, a.v};
    br_if.br_res[0] = br_result_packet_t'{a.mm, a.mask, a.mp, a.tgt};
    br_if.br_res[1] = br_result_packet_t'{b.mm, b.mask, b.mp, b.tgt};
  endtask

  // Model choice: oldest mispredict that waits on no pending mispredict; else the lowest pending slot.
  function automatic void pick(input rec_t c[$], output int s, output bit mp, output bit [31:0] tgt);
    bit blocked;
    s = -1; mp = 1'b0; tgt = '0;
    foreach (c[i]) begin
      if (!c[i].mp) continue;
      blocked = 1'b0;
      foreach (c[j]) if (c[j].mp && c[i].dep[c[j].slot]) blocked = 1'b1;
      if (!blocked && (s < 0 || c[i].slot < s)) begin
        s = c[i].slot; mp = 1'b1; tgt = c[i].tgt;
      end
    end
    if (s < 0) begin
      foreach (c[i]) if (s < 0 || c[i].slot < s) begin
        s = c[i].slot; mp = c[i].mp; tgt = c[i].tgt;
      end
    end
  endfunction

  function automatic void commit(input int s, input bit mp, input rec_t inc[$], input bit byp);
    rec_t nq[$];
    rec_t r;
    foreach (pend[i]) begin
      if (pend[i].slot == s) continue;
      if (s >= 0 && mp && pend[i].dep[s]) continue;
      r = pend[i];
      if (s >= 0 && !mp) r.dep[s] = 1'b0;
      nq.push_back(r);
    end
    foreach (inc[i]) begin
      if (byp && inc[i].slot == s) continue;
      if (s >= 0 && mp && inc[i].dep[s]) continue;
      r = inc[i];
      if (s >= 0 && !mp) r.dep[s] = 1'b0;
      nq.push_back(r);
    end
    pend = nq;
  endfunction

  task automatic step(input fu_t a, input fu_t b, input string tag);
    rec_t inc[$];
    int s; bit mp; bit [31:0] tgt; bit byp; bit [3:0] res; int cnt;
    drive(a, b);
    if (a.v) inc.push_back(mkrec(a));
    if (b.v) inc.push_back(mkrec(b));
    byp = 1'b0;
`ifdef BR_RESOLVE_BYPASS_EN
    byp = (pend.size() == 0) && (inc.size() != 0);
`endif
    if (byp) pick(inc, s, mp, tgt);
    else     pick(pend, s, mp, tgt);
    res = '0;
    if (s >= 0) res[s] = 1'b1;
    cnt = pend.size();
    @(negedge clock);
    check_out(tag, res, mp, tgt, cnt);
    @(posedge clock);
    commit(s, mp, inc, byp);
    #1;
  endtask

  task automatic rand_cycle(input int rate, input int n);
    fu_t f[2];
    bit [3:0] freem;
    int g; bit gm; bit [31:0] gt; int sl;
    int opts[$];
    freem = 4'hF;
    foreach (pend[i]) freem[pend[i].slot] = 1'b0;
    pick(pend, g, gm, gt);
    if (g >= 0) freem[g] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      f[k] = mk(0, 0, 0, 0, 0);
      opts.delete();
      for (int e = 0; e < 4; e++) if (freem[e]) opts.push_back(e);
      if (opts.size() != 0 && $urandom_range(0, 99) < rate) begin
        sl = opts[$urandom_range(0, opts.size() - 1)];
        freem[sl] = 1'b0;
        f[k].v  = 1'b1;
        f[k].mm = 4'b0001 << sl;
        foreach (pend[i]) if ($urandom_range(0, 2) == 0)
          f[k].mask = f[k].mask | (4'b0001 << pend[i].slot) | pend[i].dep;
        if (k == 1 && f[0].v && $urandom_range(0, 1) == 1) f[1].mask = f[1].mask | f[0].mm | f[0].mask;
        f[k].mask = f[k].mask & ~f[k].mm;
        f[k].mp   = ($urandom_range(0, 2) == 0);
        f[k].tgt  = $urandom;
      end
    end
    step(f[0], f[1], $sformatf("rnd%0d", n));
  endtask

  initial begin
    fu_t z, t2, t3a, t3b, t4a, t4b, t5a, t5b, t5c;
    int g; bit gm; bit [31:0] gt;

    z   = mk(0, 4'b0000, 4'b0000, 0, 32'h0);
    t2  = mk(1, 4'b0010, 4'b0000, 0, 32'h100);
    t3a = mk(1, 4'b0001, 4'b0000, 1, 32'h200);
    t3b = mk(1, 4'b0100, 4'b0001, 1, 32'h300);
    t4a = mk(1, 4'b0010, 4'b0000, 0, 32'h400);
    t4b = mk(1, 4'b1000, 4'b0010, 1, 32'h500);
    t5a = mk(1, 4'b0001, 4'b0000, 1, 32'h600);
    t5b = mk(1, 4'b0010, 4'b0000, 0, 32'h700);
    t5c = mk(1, 4'b0100, 4'b0001, 0, 32'h800);
`ifdef BR_RESOLVE_BYPASS_EN
    vt.push_back(vv(t2,  z,   4'b0010, 1, 32'h100, 0) ); vt[0].mp = 1'b0;
    vt.push_back(vv(z,   z,   4'b0000, 0, 32'h0,   0));
    vt.push_back(vv(z,   z,   4'b0000, 0, 32'h0,   0));
    vt.push_back(vv(t3a, t3b, 4'b0001, 1, 32'h200, 0));
    vt.push_back(vv(z,   z,   4'b0000, 0, 32'h0,   0));
    vt.push_back(vv(z,   z,   4'b0000, 0, 32'h0,   0));
    vt.push_back(vv(t4a, t4b, 4'b1000, 1, 32'h500, 0));
    vt.push_back(vv(z,   z,   4'b0010, 0, 32'h400, 1));
    vt.push_back(vv(z,   z,   4'b0000, 0, 32'h0,   0));
    vt.push_back(vv(z,   z,   4'b0000, 0, 32'h0,   0));
    vt.push_back(vv(t5a, t5b, 4'b0001, 1, 32'h600, 0));
    vt.push_back(vv(z,   t5c, 4'b0010, 0, 32'h700, 1));
    vt.push_back(vv(z,   z,   4'b0100, 0, 32'h800, 1));
    vt.push_back(vv(z,   z,   4'b0000, 0, 32'h0,   0));
`else
    vt.push_back(vv(t2,  z,   4'b0000, 0, 32'h0,   0));
    vt.push_back(vv(z,   z,   4'b0010, 0, 32'h100, 1));
    vt.push_back(vv(z,   z,   4'b0000, 0, 32'h0,   0));
    vt.push_back(vv(t3a, t3b, 4'b0000, 0, 32'h0,   0));
    vt.push_back(vv(z,   z,   4'b0001, 1, 32'h200, 2));
    vt.push_back(vv(z,   z,   4'b0000, 0, 32'h0,   0));
    vt.push_back(vv(t4a, t4b, 4'b0000, 0, 32'h0,   0));
    vt.push_back(vv(z,   z,   4'b1000, 1, 32'h500, 2));
    vt.push_back(vv(z,   z,   4'b0010, 0, 32'h400, 1));
    vt.push_back(vv(z,   z,   4'b0000, 0, 32'h0,   0));
    vt.push_back(vv(t5a, t5b, 4'b0000, 0, 32'h0,   0));
    vt.push_back(vv(z,   t5c, 4'b0001, 1, 32'h600, 2));
    vt.push_back(vv(z,   z,   4'b0010, 0, 32'h700, 1));
    vt.push_back(vv(z,   z,   4'b0000, 0, 32'h0,   0));
`endif

    drive(z, z);
    #12;
    check_out("reset", 4'b0000, 1'b0, 32'h0, 0);
    #10 reset = 1'b1;
    @(posedge clock); #1;

    foreach (vt[i]) begin
      drive(vt[i].f0, vt[i].f1);
      @(negedge clock);
      check_out($sformatf("vec%0d", i), vt[i].res, vt[i].mp, vt[i].tgt, vt[i].cnt);
      @(posedge clock); #1;
    end

    // Refill the slot being emitted in the same cycle.
    step(mk(1, 4'b0010, 4'b0000, 0, 32'h1111), mk(1, 4'b0100, 4'b0000, 0, 32'h2222), "ww0");
    pick(pend, g, gm, gt);
    if (g < 0) check("ww_setup", 32'hFFFFFFFF, 32'h0);
    else step(mk(1, 4'b0001 << g, 4'b0000, 1, 32'h3333), z, "ww1");
    for (int i = 0; i < 4; i++) step(z, z, $sformatf("ww_drain%0d", i));

    for (int n = 0; n < 600; n++) rand_cycle((n < 300) ? 70 : 20, n);
    for (int i = 0; i < 6; i++) step(z, z, $sformatf("drain%0d", i));

    // Asynchronous reset while entries are pending and new input is presented.
    step(mk(1, 4'b0001, 4'b0000, 0, 32'h4444), mk(1, 4'b1000, 4'b0001, 0, 32'h5555), "rst0");
    drive(mk(1, 4'b0010, 4'b0000, 0, 32'h6666), z);
    #2 reset = 1'b0;
    #1 check_out("rst_mid", 4'b0000, 1'b0, 32'h0, 0);
    pend.delete();
    @(posedge clock); #1;
    check_out("rst_hold", 4'b0000, 1'b0, 32'h0, 0);
    drive(z, z);
    #2 reset = 1'b1;
    @(posedge clock); #1;
    step(z, z, "post0");
    step(z, z, "post1");
    step(t2, z, "post2");
    step(z, z, "post3");
    step(z, z, "post4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
